// File: rtl/ifu_fetch.sv
// Fetch stage: credit-limited sequential imem requests, in-order PC tag queue and a small
// instruction FIFO toward the core; redirects flush the FIFO and drop wrong-path responses.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000000080000000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [63:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;

  // fetch_pc is the PC of the next request to raise; it advances when a request is raised,
  // so a still-pending wrong-path request cannot disturb a redirect target.
  logic [63:0]   fetch_pc;
  logic [63:0]   req_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] inflight_next;
  logic [PW-1:0] tag_wr;
  logic [PW-1:0] tag_rd;
  logic [PW-1:0] fifo_wr;
  logic [PW-1:0] fifo_rd;
  logic [63:0]   tag_mem  [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [63:0]   pc_mem   [DEPTH];
  logic [OW-1:0] occupancy;
  logic          req_hs;
  logic          raise;
  logic          push;
  logic          pop;
  logic [63:0]   resp_pc;
  logic [31:0]   resp_inst;

  always_comb begin
    inst_valid    = (fifo_count != '0);
    inst          = inst_valid ? inst_mem[fifo_rd] : '0;
    inst_pc       = inst_valid ? pc_mem[fifo_rd] : '0;
    req_hs        = imem_req_valid & imem_req_ready;
    occupancy     = OW'(inflight) + OW'(fifo_count);
    raise         = (occupancy < OW'(DEPTH)) & ~redirect_valid & (~imem_req_valid | req_hs);
    // a raised-but-unaccepted request already counts as in flight
    inflight_next = inflight + CW'(raise) - CW'(imem_resp_valid);
    resp_pc       = tag_mem[tag_rd];
    resp_inst     = resp_pc[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];
    push          = imem_resp_valid & (drop == '0) & ~redirect_valid;
    pop           = inst_valid & inst_ready & ~redirect_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc       <= RESET_PC;
      req_pc         <= '0;
      imem_req_valid <= 1'b0;
      imem_req_addr  <= '0;
      inflight       <= '0;
      drop           <= '0;
      tag_wr         <= '0;
      tag_rd         <= '0;
      fifo_wr        <= '0;
      fifo_rd        <= '0;
      fifo_count     <= '0;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~64'h3;
      end else if (raise) begin
        fetch_pc <= fetch_pc + 64'd4;
      end

      if (raise) begin
        imem_req_valid <= 1'b1;
        imem_req_addr  <= fetch_pc & ~64'h7;
        req_pc         <= fetch_pc;
      end else if (req_hs) begin
        imem_req_valid <= 1'b0;
      end

      inflight <= inflight_next;
      if (req_hs)          tag_wr <= tag_wr + 1'b1;
      if (imem_resp_valid) tag_rd <= tag_rd + 1'b1;

      if (redirect_valid) begin
        drop <= inflight_next;
      end else if (imem_resp_valid && drop != '0) begin
        drop <= drop - 1'b1;
      end

      if (redirect_valid) begin
        fifo_wr    <= '0;
        fifo_rd    <= '0;
        fifo_count <= '0;
      end else begin
        if (push) fifo_wr <= fifo_wr + 1'b1;
        if (pop)  fifo_rd <= fifo_rd + 1'b1;
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_hs) tag_mem[tag_wr] <= req_pc;
    if (push) begin
      inst_mem[fifo_wr] <= resp_inst;
      pc_mem[fifo_wr]   <= resp_pc;
    end
  end

endmodule
